// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - load-use stall, EX operand forwarding and ID bypass control for the 5-stage pipeline
// Optional macro HAZARD_STATS_EN adds a saturating stall-cycle counter on stall_cnt.
module hazard_forward_ctrl #(
   parameter int REG_ADDR_W  = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   id_valid,
   input  logic [REG_ADDR_W-1:0]  id_rs,
   input  logic [REG_ADDR_W-1:0]  id_rt,
   input  logic                   id_uses_rt,
   input  logic [REG_ADDR_W-1:0]  id_dst,
   input  logic                   id_regwrite,
   input  logic                   id_memread,
   output logic                   pc_write,
   output logic                   ifid_write,
   output logic                   idex_flush,
   output logic [1:0]             fwd_a,
   output logic [1:0]             fwd_b,
   output logic                   id_byp_rs,
   output logic                   id_byp_rt,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic                  usesRt;
      logic [REG_ADDR_W-1:0] dst;
      logic                  regwrite;
      logic                  memread;
   } exStage_t;

   // MEM and WB only need the producer side of the shadow
   exStage_t              exQ;
   logic                  memValid;
   logic                  memRegwrite;
   logic                  memMemread;
   logic [REG_ADDR_W-1:0] memDst;
   logic                  wbValid;
   logic                  wbRegwrite;
   logic [REG_ADDR_W-1:0] wbDst;

   logic stall;
   logic loadPending;
   logic memFwdOk;
   logic wbFwdOk;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exQ         <= '0;
         memValid    <= 1'b0;
         memRegwrite <= 1'b0;
         memMemread  <= 1'b0;
         memDst      <= '0;
         wbValid     <= 1'b0;
         wbRegwrite  <= 1'b0;
         wbDst       <= '0;
      end else begin
         wbValid     <= memValid;
         wbRegwrite  <= memRegwrite;
         wbDst       <= memDst;
         memValid    <= exQ.valid;
         memRegwrite <= exQ.regwrite;
         memMemread  <= exQ.memread;
         memDst      <= exQ.dst;
         if (stall) begin
            exQ <= '0;
         end else begin
            exQ <= '{valid: id_valid, rs: id_rs, rt: id_rt, usesRt: id_uses_rt,
                     dst: id_dst, regwrite: id_regwrite, memread: id_memread};
         end
      end
   end

   // A load result is not available until WB, so MEM never forwards a load
   assign loadPending = exQ.valid & exQ.memread & exQ.regwrite & (exQ.dst != '0);
   assign memFwdOk    = memValid & memRegwrite & ~memMemread & (memDst != '0);
   assign wbFwdOk     = wbValid & wbRegwrite & (wbDst != '0);

   assign stall = id_valid & loadPending &
                  ((exQ.dst == id_rs) | (id_uses_rt & (exQ.dst == id_rt)));

   assign pc_write   = ~stall;
   assign ifid_write = ~stall;
   assign idex_flush = stall;

   always_comb begin
      fwd_a = 2'b00;
      if (memFwdOk && (memDst == exQ.rs)) begin
         fwd_a = 2'b10;
      end else if (wbFwdOk && (wbDst == exQ.rs)) begin
         fwd_a = 2'b01;
      end
   end

   always_comb begin
      fwd_b = 2'b00;
      if (exQ.usesRt) begin
         if (memFwdOk && (memDst == exQ.rt)) begin
            fwd_b = 2'b10;
         end else if (wbFwdOk && (wbDst == exQ.rt)) begin
            fwd_b = 2'b01;
         end
      end
   end

   assign id_byp_rs = wbFwdOk & (wbDst == id_rs);
   assign id_byp_rt = wbFwdOk & (wbDst == id_rt);

`ifdef HAZARD_STATS_EN
   logic [STALL_CNT_W-1:0] stallCntQ;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stallCntQ <= '0;
      end else if (stall && (stallCntQ != '1)) begin
         stallCntQ <= stallCntQ + STALL_CNT_W'(1);
      end
   end

   assign stall_cnt = stallCntQ;
`else
   assign stall_cnt = '0;
`endif

endmodule
